// File: rtl/eth_mii_tx_sched.sv
// Two-requester MII transmit scheduler: round-robin frame grant, preamble/SFD
// generation, nibble serialisation, underrun/oversize abort with drain, and IFG.
module eth_mii_tx_sched #(
  parameter int PRE_NIBBLES = 15,
  parameter int IFG_NIBBLES = 24,
  parameter int MAX_BYTES   = 1522
) (
  input  logic        eth_mac_clock,
  input  logic        eth_mac_rstn,
  input  logic        sched_enable,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [3:0]  eth_mii_txd,
  output logic        eth_mii_tx_en,
  output logic        eth_mii_tx_er,
  output logic [1:0]  grant,
  output logic        frame_done,
  output logic        frame_abort
);

  // Handshake: requester i transfers req_data[8i+7:8i]/req_last[i] on a rising
  // edge where req_valid[i] && req_ready[i]. req_ready depends on registered
  // state only, so a requester may not wait for ready before raising valid.
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA_LO, S_DATA_HI, S_ABORT, S_DRAIN, S_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [10:0] bcnt_q, bcnt_d;

  logic        gsel;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic        cap_hit;
  logic [1:0]  elig;
  logic        pick;

  assign gsel      = grant_q[1];
  assign sel_valid = req_valid[gsel];
  assign sel_last  = req_last[gsel];
  assign sel_data  = gsel ? req_data[15:8] : req_data[7:0];
  assign cap_hit   = (bcnt_q == 11'(MAX_BYTES));
  assign elig      = req_valid & {2{sched_enable}};
  assign grant     = grant_q;

  always_ff @(posedge eth_mac_clock or negedge eth_mac_rstn) begin
    if (!eth_mac_rstn) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= 16'd0;
      byte_q  <= 8'd0;
      last_q  <= 1'b0;
      bcnt_q  <= 11'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    byte_d        = byte_q;
    last_d        = last_q;
    bcnt_d        = bcnt_q;
    pick          = 1'b0;
    req_ready     = 2'b00;
    eth_mii_txd   = 4'h0;
    eth_mii_tx_en = 1'b0;
    eth_mii_tx_er = 1'b0;
    frame_done    = 1'b0;
    frame_abort   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          // Contention goes to the pointer; otherwise the lone requester wins.
          pick    = (elig == 2'b11) ? ptr_q : elig[1];
          grant_d = pick ? 2'b10 : 2'b01;
          ptr_d   = ~pick;
          cnt_d   = 16'd0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        eth_mii_txd   = 4'h5;
        eth_mii_tx_en = 1'b1;
        if (cnt_q == 16'(PRE_NIBBLES - 1)) begin
          cnt_d   = 16'd0;
          state_d = S_SFD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SFD: begin
        eth_mii_txd   = 4'hD;
        eth_mii_tx_en = 1'b1;
        req_ready     = grant_q;
        if (sel_valid) begin
          byte_d  = sel_data;
          last_d  = sel_last;
          bcnt_d  = 11'd1;
          state_d = S_DATA_LO;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_DATA_LO: begin
        eth_mii_txd   = byte_q[3:0];
        eth_mii_tx_en = 1'b1;
        state_d       = S_DATA_HI;
      end
      S_DATA_HI: begin
        eth_mii_txd   = byte_q[7:4];
        eth_mii_tx_en = 1'b1;
        if (last_q) begin
          frame_done = 1'b1;
          grant_d    = 2'b00;
          cnt_d      = 16'd0;
          state_d    = S_IFG;
        end else if (cap_hit) begin
          state_d = S_ABORT;
        end else begin
          req_ready = grant_q;
          if (sel_valid) begin
            byte_d  = sel_data;
            last_d  = sel_last;
            if (bcnt_q != 11'h7FF) bcnt_d = bcnt_q + 11'd1;
            state_d = S_DATA_LO;
          end else begin
            state_d = S_ABORT;
          end
        end
      end
      S_ABORT: begin
        eth_mii_tx_en = 1'b1;
        eth_mii_tx_er = 1'b1;
        frame_abort   = 1'b1;
        state_d       = S_DRAIN;
      end
      S_DRAIN: begin
        req_ready = grant_q;
        if (sel_valid && sel_last) begin
          grant_d = 2'b00;
          cnt_d   = 16'd0;
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        if (cnt_q == 16'(IFG_NIBBLES - 1)) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_mii_tx_sched.sv
// Directed bench for eth_mii_tx_sched: byte sources per requester, a wire
// monitor that logs every enabled nibble, and an expected-nibble queue.
module tb_eth_mii_tx_sched;

  logic        eth_mac_clock = 1'b0;
  logic        eth_mac_rstn  = 1'b0;
  logic        sched_enable  = 1'b0;
  logic [1:0]  req_valid     = 2'b00;
  logic [15:0] req_data      = 16'h0000;
  logic [1:0]  req_last      = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  eth_mii_txd;
  logic        eth_mii_tx_en;
  logic        eth_mii_tx_er;
  logic [1:0]  grant;
  logic        frame_done;
  logic        frame_abort;

  eth_mii_tx_sched #(.MAX_BYTES(4)) dut (
    .eth_mac_clock (eth_mac_clock),
    .eth_mac_rstn  (eth_mac_rstn),
    .sched_enable  (sched_enable),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .eth_mii_txd   (eth_mii_txd),
    .eth_mii_tx_en (eth_mii_tx_en),
    .eth_mii_tx_er (eth_mii_tx_er),
    .grant         (grant),
    .frame_done    (frame_done),
    .frame_abort   (frame_abort)
  );

  always #5 eth_mac_clock = ~eth_mac_clock;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  logic [4:0]  wire_q[$];
  logic [4:0]  exp_q[$];
  logic [1:0]  gseq[$];
  int          done_cyc[$];
  int          rise_cyc[$];
  logic [1:0]  prev_grant = 2'b00;
  // Source entries: {gap cycles before this byte[12:9], last[8], data[7:0]}
  logic [12:0] src0_q[$];
  logic [12:0] src1_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    logic [12:0] h;
    req_valid = 2'b00;
    if (src0_q.size() > 0) begin
      h = src0_q[0];
      req_data[7:0] = h[7:0];
      req_last[0]   = h[8];
      if (h[12:9] != 4'd0) begin
        h[12:9]   = h[12:9] - 4'd1;
        src0_q[0] = h;
      end else begin
        req_valid[0] = 1'b1;
      end
    end
    if (src1_q.size() > 0) begin
      h = src1_q[0];
      req_data[15:8] = h[7:0];
      req_last[1]    = h[8];
      if (h[12:9] != 4'd0) begin
        h[12:9]   = h[12:9] - 4'd1;
        src1_q[0] = h;
      end else begin
        req_valid[1] = 1'b1;
      end
    end
  endtask

  task automatic step();
    logic [1:0] acc;
    acc = req_valid & req_ready;
    @(posedge eth_mac_clock);
    @(negedge eth_mac_clock);
    cyc++;
    if (eth_mii_tx_en) wire_q.push_back({eth_mii_tx_er, eth_mii_txd});
    if (frame_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (frame_abort) abort_cnt++;
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      gseq.push_back(grant);
      rise_cyc.push_back(cyc);
    end
    prev_grant = grant;
    check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
    if (acc[0]) src0_q.delete(0);
    if (acc[1]) src1_q.delete(0);
    present();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    wire_q.delete();
    exp_q.delete();
    gseq.delete();
    done_cyc.delete();
    rise_cyc.delete();
    done_cnt  = 0;
    abort_cnt = 0;
  endtask

  task automatic exp_pre();
    for (int i = 0; i < 15; i++) exp_q.push_back(5'h05);
    exp_q.push_back(5'h0D);
  endtask

  task automatic exp_byte(input logic [7:0] b);
    exp_q.push_back({1'b0, b[3:0]});
    exp_q.push_back({1'b0, b[7:4]});
  endtask

  task automatic cmp_wire(input string tag);
    check({tag, "_len"}, 32'(wire_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wire_q.size(); i++)
      check($sformatf("%s_nib%0d", tag, i), 32'(wire_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    eth_mac_rstn = 1'b0;
    @(posedge eth_mac_clock);
    @(negedge eth_mac_clock);
    eth_mac_rstn = 1'b1;
    prev_grant   = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_logs();
    repeat (2) @(negedge eth_mac_clock);
    eth_mac_rstn = 1'b1;
    #1;
    check("rst_en",    32'(eth_mii_tx_en), 32'd0);
    check("rst_er",    32'(eth_mii_tx_er), 32'd0);
    check("rst_txd",   32'(eth_mii_txd),   32'd0);
    check("rst_ready", 32'(req_ready),     32'd0);
    check("rst_grant", 32'(grant),         32'd0);
    check("rst_done",  32'(frame_done),    32'd0);
    check("rst_abort", 32'(frame_abort),   32'd0);
    sched_enable = 1'b1;

    // Two-byte clean frame from requester 0
    src0_q.push_back({4'd0, 1'b0, 8'hA5});
    src0_q.push_back({4'd0, 1'b1, 8'h3C});
    present();
    run(50);
    exp_pre(); exp_byte(8'hA5); exp_byte(8'h3C);
    cmp_wire("t1");
    check("t1_done",  32'(done_cnt),      32'd1);
    check("t1_abort", 32'(abort_cnt),     32'd0);
    check("t1_grant", 32'(grant),         32'd0);
    check("t1_en",    32'(eth_mii_tx_en), 32'd0);
    check("t1_src",   32'(src0_q.size()), 32'd0);

    // Round-robin with both requesters pending out of reset
    do_reset();
    clear_logs();
    src0_q.push_back({4'd0, 1'b1, 8'h11});
    src0_q.push_back({4'd0, 1'b1, 8'h33});
    src1_q.push_back({4'd0, 1'b1, 8'h22});
    present();
    run(140);
    exp_pre(); exp_byte(8'h11);
    exp_pre(); exp_byte(8'h22);
    exp_pre(); exp_byte(8'h33);
    cmp_wire("t2");
    check("t2_done",  32'(done_cnt),    32'd3);
    check("t2_ngr",   32'(gseq.size()), 32'd3);
    if (gseq.size() == 3) begin
      check("t2_g0", 32'(gseq[0]), 32'd1);
      check("t2_g1", 32'(gseq[1]), 32'd2);
      check("t2_g2", 32'(gseq[2]), 32'd1);
    end
    if (done_cyc.size() > 0 && rise_cyc.size() > 1)
      check("t2_ifg_gap", 32'(rise_cyc[1] - done_cyc[0]), 32'd26);
    else
      check("t2_ifg_events", 32'(rise_cyc.size()), 32'd3);

    // Underrun on requester 1 after its first byte, then drain to last
    clear_logs();
    src1_q.push_back({4'd0, 1'b0, 8'h81});
    src1_q.push_back({4'd3, 1'b0, 8'h82});
    src1_q.push_back({4'd0, 1'b0, 8'h83});
    src1_q.push_back({4'd0, 1'b1, 8'h84});
    present();
    run(60);
    exp_pre(); exp_byte(8'h81); exp_q.push_back(5'h10);
    cmp_wire("t3");
    check("t3_done",  32'(done_cnt),      32'd0);
    check("t3_abort", 32'(abort_cnt),     32'd1);
    check("t3_src",   32'(src1_q.size()), 32'd0);
    check("t3_grant", 32'(grant),         32'd0);
    if (gseq.size() > 0) check("t3_owner", 32'(gseq[0]), 32'd2);
    else check("t3_ngr", 32'(gseq.size()), 32'd1);

    // Six-byte frame against a four-byte cap
    clear_logs();
    for (int i = 1; i <= 6; i++) src0_q.push_back({4'd0, (i == 6), 8'(i)});
    present();
    run(70);
    exp_pre();
    for (int i = 1; i <= 4; i++) exp_byte(8'(i));
    exp_q.push_back(5'h10);
    cmp_wire("t4");
    check("t4_done",  32'(done_cnt),      32'd0);
    check("t4_abort", 32'(abort_cnt),     32'd1);
    check("t4_src",   32'(src0_q.size()), 32'd0);

    // Exactly-at-cap frame ending with last is sent cleanly
    clear_logs();
    src0_q.push_back({4'd0, 1'b0, 8'h11});
    src0_q.push_back({4'd0, 1'b0, 8'h22});
    src0_q.push_back({4'd0, 1'b0, 8'h33});
    src0_q.push_back({4'd0, 1'b1, 8'h44});
    present();
    run(60);
    exp_pre(); exp_byte(8'h11); exp_byte(8'h22); exp_byte(8'h33); exp_byte(8'h44);
    cmp_wire("t4b");
    check("t4b_done",  32'(done_cnt),  32'd1);
    check("t4b_abort", 32'(abort_cnt), 32'd0);

    // Reset during DATA_LO, then a fresh frame from the pending byte
    clear_logs();
    src0_q.push_back({4'd0, 1'b0, 8'h5A});
    src0_q.push_back({4'd0, 1'b1, 8'h6B});
    present();
    for (int i = 0; i < 40 && wire_q.size() < 17; i++) step();
    check("t5_reach_lo", 32'(wire_q.size()), 32'd17);
    if (wire_q.size() == 17) check("t5_lo_nib", 32'(wire_q[16]), 32'h0A);
    eth_mac_rstn = 1'b0;
    #1;
    check("t5_rst_en",    32'(eth_mii_tx_en), 32'd0);
    check("t5_rst_er",    32'(eth_mii_tx_er), 32'd0);
    check("t5_rst_ready", 32'(req_ready),     32'd0);
    check("t5_rst_grant", 32'(grant),         32'd0);
    check("t5_rst_txd",   32'(eth_mii_txd),   32'd0);
    check("t5_rst_done",  32'(frame_done),    32'd0);
    check("t5_rst_abort", 32'(frame_abort),   32'd0);
    @(posedge eth_mac_clock);
    @(negedge eth_mac_clock);
    eth_mac_rstn = 1'b1;
    prev_grant   = 2'b00;
    #1;
    check("t5_rel_ready", 32'(req_ready), 32'd0);
    check("t5_rel_grant", 32'(grant),     32'd0);
    clear_logs();
    run(50);
    exp_pre(); exp_byte(8'h6B);
    cmp_wire("t5");
    check("t5_done",  32'(done_cnt),  32'd1);
    check("t5_abort", 32'(abort_cnt), 32'd0);

    // Enable gating: no grant while disabled; dropping enable mid-frame
    clear_logs();
    sched_enable = 1'b0;
    src0_q.push_back({4'd0, 1'b1, 8'h77});
    present();
    run(10);
    check("t6_off_grant", 32'(grant),         32'd0);
    check("t6_off_wire",  32'(wire_q.size()), 32'd0);
    sched_enable = 1'b1;
    step();
    check("t6_on_grant", 32'(grant), 32'd1);
    sched_enable = 1'b0;
    src1_q.push_back({4'd0, 1'b1, 8'h99});
    present();
    run(60);
    exp_pre(); exp_byte(8'h77);
    cmp_wire("t6");
    check("t6_done",   32'(done_cnt),      32'd1);
    check("t6_ngr",    32'(gseq.size()),   32'd1);
    check("t6_grant",  32'(grant),         32'd0);
    check("t6_src1",   32'(src1_q.size()), 32'd1);
    check("t6_src0",   32'(src0_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_mii_tx_sched.md
ETH_MII_TX_SCHED -- requirements
Module: eth_mii_tx_sched

Interface
REQ-001 SHALL have parameter PRE_NIBBLES, default 15, count of 0x5 preamble nibbles before the SFD nibble.
REQ-002 SHALL have parameter IFG_NIBBLES, default 24, idle cycles between frames (96 bit times).
REQ-003 SHALL have parameter MAX_BYTES, default 1522, frame byte cap; the byte counter is 11 bits and saturating.
REQ-004 SHALL use reset eth_mac_rstn, asynchronous, active-low; clock eth_mac_clock.
REQ-005 Ports: eth_mac_clock  in  1  clock.
REQ-006 Ports: eth_mac_rstn  in  1  async active-low reset.
REQ-007 Ports: sched_enable  in  1  permits new frame grants.
REQ-008 Ports: req_valid  in  2  per-requester byte valid.
REQ-009 Ports: req_data  in  16  requester i byte on [8i+7:8i].
REQ-010 Ports: req_last  in  2  byte is final byte of frame.
REQ-011 Ports: req_ready  out  2  byte accepted when valid&ready.
REQ-012 Ports: eth_mii_txd  out  4  MII TX nibble.
REQ-013 Ports: eth_mii_tx_en  out  1  MII TX enable.
REQ-014 Ports: eth_mii_tx_er  out  1  MII TX error.
REQ-015 Ports: grant  out  2  one-hot owner of the TX path; 0 when idle.
REQ-016 Ports: frame_done  out  1  one-cycle pulse, frame sent cleanly.
REQ-017 Ports: frame_abort  out  1  one-cycle pulse, frame aborted.

Function
REQ-018 SHALL implement FSM states IDLE, PRE, SFD, DATA_LO, DATA_HI, ABORT, DRAIN, IFG.
REQ-019 Outputs SHALL derive from registered state only; no combinational path from req_* to eth_mii_*.
REQ-020 IDLE: txd=0, en=0, req_ready=0; if sched_enable and any req_valid, grant and move to PRE next cycle.
REQ-021 Arbitration SHALL be round-robin at frame granularity: priority pointer moves to the other requester after each grant; pointer favors requester 0 out of reset.
REQ-022 grant SHALL be held from PRE entry until IFG entry; it SHALL NOT change mid-frame.
REQ-023 PRE: txd=0x5, en=1 for PRE_NIBBLES cycles; then SFD.
REQ-024 SFD: txd=0xD, en=1, req_ready[g]=1 for one cycle; on valid, capture byte and last, then DATA_LO; otherwise underrun, go to ABORT.
REQ-025 DATA_LO: txd=byte[3:0], en=1, req_ready=0; then DATA_HI.
REQ-026 DATA_HI: txd=byte[7:4], en=1; req_ready[g]=1 unless held last=1 or cap reached.
REQ-027 In DATA_HI: held last=1 goes to IFG with frame_done pulse; accepted byte goes to DATA_LO; valid=0 with ready=1 is underrun, go to ABORT.
REQ-028 Byte counter increments per accepted byte; when accepted byte makes count==MAX_BYTES with last=0, its DATA_HI SHALL deassert ready and go to ABORT.
REQ-029 ABORT: txd=0x0, en=1, er=1 for one cycle, frame_abort pulse; then DRAIN.
REQ-030 DRAIN: en=0, req_ready[g]=1; discard bytes until valid&last accepted, then IFG.
REQ-031 IFG: en=0, er=0, req_ready=0 for IFG_NIBBLES cycles; grant cleared; then IDLE.
REQ-032 sched_enable deassertion SHALL only block IDLE grants; an in-flight frame completes normally.
REQ-033 Nibble order SHALL be low nibble first per MII.

Reset
REQ-034 On eth_mac_rstn low, asynchronously: state IDLE, txd=0, en=0, er=0, req_ready=0, grant=0, pulses 0, counters 0, pointer to requester 0.
REQ-035 Reset mid-frame SHALL drop the frame with no frame_done/frame_abort pulse; no ready after release until a new grant.

Verification
REQ-036 Req0 sends 2-byte frame 0xA5,0x3C(last) -> en=1 for 20 cycles: 15x 0x5, 0xD, 0x5,0xA,0xC,0x3; frame_done once; 24 idle cycles.
REQ-037 Both requesters valid in IDLE from reset -> req0 frame, IFG, req1 frame, then req0 again; grant never overlaps.
REQ-038 Req1 drops valid after 1st byte, resumes 3 cycles later -> er=1 one cycle after that byte's high nibble, frame_abort, remaining bytes drained to last, en=0 during drain.
REQ-039 MAX_BYTES=4, 6-byte frame -> 4 bytes on wire, then ABORT cycle (er=1), bytes 5-6 drained, frame_done never pulses.
REQ-040 Reset asserted during DATA_LO -> en, er, req_ready, grant 0 same cycle; after release, pending valid starts fresh preamble.
REQ-041 sched_enable=0 with req_valid=01 -> stays IDLE, grant=0; enable dropped mid-frame -> frame finishes, no new grant.
